// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, FSM state encoding and default datapath width shared by the
// execute unit and the upstream ALU control decoder.
package alu_pkg;
    localparam int ALU_WIDTH = 32;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;
endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle shifter; done is asserted during the final shift cycle
// and dout then carries the fully shifted value.
module alu_shift_iter #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     en,
    input  logic                     left,
    input  logic                     arith,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic [WIDTH-1:0]         dout,
    output logic                     done
);
    localparam int SHW = $clog2(WIDTH);
    logic [WIDTH-1:0] w;
    logic [SHW-1:0] cnt;
    logic l, ar;
    assign dout = l ? {w[WIDTH-2:0], 1'b0} : {ar & w[WIDTH-1], w[WIDTH-1:1]};
    assign done = en && cnt == SHW'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w   <= '0;
            cnt <= '0;
            l   <= 1'b0;
            ar  <= 1'b0;
        end else if (start) begin
            w   <= din;
            cnt <= shamt;
            l   <= left;
            ar  <= arith;
        end else if (en) begin
            w   <= dout;
            cnt <= cnt - SHW'(1);
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes. Shifts are iterative unless
// ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic             sra_sel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int SHW = $clog2(WIDTH);
    localparam int M = WIDTH - 1;
    alu_state_e state, state_n;
    logic [WIDTH-1:0] sum, diff, shift_imm, op_res, sh_dout, nxt_res;
    logic [SHW-1:0] shamt;
    logic is_shift, use_iter, sh_done, op_ovf, load;
    assign shamt = src_b[SHW-1:0];
    assign is_shift = alu_ctrl == ALU_SLL || alu_ctrl == ALU_SRL;
    assign sum = src_a + src_b;
    assign diff = src_a - src_b;
`ifdef ALU_FAST_SHIFT_EN
    assign shift_imm = alu_ctrl == ALU_SLL ? src_a << shamt :
                       sra_sel ? WIDTH'($signed(src_a) >>> shamt) : src_a >> shamt;
    assign use_iter = 1'b0;
    assign sh_done = 1'b0;
    assign sh_dout = '0;
`else
    // A zero shift amount needs no iterations, so it completes like a single-cycle op.
    assign shift_imm = src_a;
    assign use_iter = is_shift && shamt != '0;
    alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .start (in_ready && in_valid && use_iter),
        .en    (state == SHIFT),
        .left  (alu_ctrl == ALU_SLL),
        .arith (sra_sel),
        .din   (src_a),
        .shamt (shamt),
        .dout  (sh_dout),
        .done  (sh_done)
    );
`endif
    assign op_res = alu_ctrl == ALU_ADD ? sum :
                    alu_ctrl == ALU_SUB ? diff :
                    alu_ctrl == ALU_XOR ? src_a ^ src_b :
                    alu_ctrl == ALU_OR  ? src_a | src_b :
                    alu_ctrl == ALU_AND ? src_a & src_b :
                    is_shift ? shift_imm : '0;
    assign op_ovf = alu_ctrl == ALU_ADD ? (src_a[M] == src_b[M] && sum[M] != src_a[M]) :
                    alu_ctrl == ALU_SUB ? (src_a[M] != src_b[M] && diff[M] != src_a[M]) : 1'b0;
    assign nxt_res = state == SHIFT ? sh_dout : op_res;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        state_n = state;
        load = 1'b0;
        if (state == IDLE && in_valid) begin
            state_n = use_iter ? SHIFT : DONE;
            load = !use_iter;
        end else if (state == SHIFT && sh_done) begin
            state_n = DONE;
            load = 1'b1;
        end else if (state == DONE && out_ready) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            result <= nxt_res;
            zero   <= nxt_res == '0;
            neg    <= nxt_res[M];
            ovf    <= state == IDLE && op_ovf;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench; issued ops push model results, a monitor pops and checks
// value, flags, latency and hold behaviour under backpressure.
module tb_alu_exec_unit;
    logic clk, rst_n, in_valid, in_ready, sra_sel, out_valid, out_ready, zero, neg, ovf;
    logic [2:0] alu_ctrl;
    logic [31:0] src_a, src_b, result;
    int total = 0, bad = 0, cyc = 0;
    bit dir_phase = 1;

    typedef struct {
        logic [31:0] r;
        logic z, n, o;
        int lat, acc;
    } exp_t;
    exp_t q[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .sra_sel(sra_sel), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .neg(neg), .ovf(ovf)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input bit [2:0] c, input bit s, input bit [31:0] a, input bit [31:0] b);
        exp_t m;
        int sh = int'(b[4:0]);
        longint t;
        m.o = 0;
        case (c)
            3'd0: begin t = longint'($signed(a)) + longint'($signed(b)); m.r = 32'(t); m.o = t != longint'($signed(m.r)); end
            3'd2: begin t = longint'($signed(a)) - longint'($signed(b)); m.r = 32'(t); m.o = t != longint'($signed(m.r)); end
            3'd1: m.r = a << sh;
            3'd5: m.r = s ? 32'($signed(a) >>> sh) : a >> sh;
            3'd4: m.r = a ^ b;
            3'd6: m.r = a | b;
            3'd7: m.r = a & b;
            default: m.r = 0;
        endcase
        m.z = m.r == 0;
        m.n = m.r[31];
`ifdef ALU_FAST_SHIFT_EN
        m.lat = 1;
`else
        m.lat = ((c == 3'd1 || c == 3'd5) && sh != 0) ? sh + 1 : 1;
`endif
        m.acc = 0;
        return m;
    endfunction

    task automatic issue(input bit [2:0] c, input bit s, input bit [31:0] a, input bit [31:0] b);
        exp_t e;
        bit acc = 0;
        @(negedge clk);
        alu_ctrl = c; sra_sel = s; src_a = a; src_b = b; in_valid = 1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (in_ready) begin
                e = model(c, s, a, b);
                e.acc = cyc;
                q.push_back(e);
                acc = 1;
                @(posedge clk);
            end else @(negedge clk);
        end
        if (!acc) chk("accept_timeout", 0, 1);
        #1;
        in_valid = 0;
        alu_ctrl = 3'($urandom); sra_sel = 1'($urandom); src_a = $urandom; src_b = $urandom;
    endtask

    initial begin : monitor
        bit holding = 0, retired = 0;
        int hc = 0, hreq = 0;
        logic [34:0] held = 0;
        exp_t e;
        out_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 0; retired = 0; out_ready = 0;
            end else begin
                if (retired) begin
                    chk("idle_after_retire", 32'(out_valid), 0);
                    retired = 0;
                end
                if (out_valid) begin
                    chk("in_ready_busy", 32'(in_ready), 0);
                    if (!holding) begin
                        if (q.size() == 0) chk("spurious_valid", 32'(out_valid), 0);
                        else begin
                            e = q.pop_front();
                            chk("result", result, e.r);
                            chk("zero", 32'(zero), 32'(e.z));
                            chk("neg", 32'(neg), 32'(e.n));
                            chk("ovf", 32'(ovf), 32'(e.o));
                            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                        end
                        held = {result, zero, neg, ovf};
                        holding = 1; hc = 0;
                        hreq = dir_phase ? 3 : int'($urandom_range(0, 2));
                    end else begin
                        chk("hold_stable", 32'({result, zero, neg, ovf} != held), 0);
                        hc++;
                    end
                    out_ready = hc >= hreq;
                    if (out_ready) begin retired = 1; holding = 0; end
                end else out_ready = 1'($urandom);
            end
        end
    end

    initial begin : stim
        in_valid = 0; alu_ctrl = 0; sra_sel = 0; src_a = 0; src_b = 0;
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_flags", 32'({zero, neg, ovf}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        issue(3'd0, 0, 32'h5, 32'h7);
        issue(3'd2, 0, 32'h3, 32'h3);
        issue(3'd2, 0, 32'h8000_0000, 32'h1);
        issue(3'd1, 0, 32'h1, 32'd31);
        issue(3'd1, 0, 32'h1, 32'd0);
        issue(3'd5, 0, 32'h8000_0000, 32'd4);
        issue(3'd5, 1, 32'h8000_0000, 32'd4);
        issue(3'd5, 0, 32'hFFFF_FFFF, 32'd31);
        issue(3'd5, 1, 32'hFFFF_FFFF, 32'd31);
        issue(3'd3, 0, 32'h1234_5678, 32'h1);
        issue(3'd0, 0, 32'h7FFF_FFFF, 32'h1);
        dir_phase = 0;
        for (int i = 0; i < 150; i++)
            issue(3'($urandom), 1'($urandom), $urandom, $urandom);
        for (int i = 0; i < 400 && (q.size() != 0 || out_valid); i++) @(negedge clk);
        chk("drain", 32'(q.size()), 0);
        // abort a 20-bit shift with reset in its fifth cycle
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        alu_ctrl = 3'd1; sra_sel = 0; src_a = 32'hFFFF_FFFF; src_b = 32'd20; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_result", result, 0);
        chk("abort_flags", 32'({zero, neg, ovf}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("no_valid_after_abort", 32'(out_valid), 0);
        end
        issue(3'd6, 0, 32'hF0F0_0000, 32'h0000_0F0F);
        for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) @(negedge clk);
        chk("final_drain", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
